// File: rtl/dvi_i2c_init_seq.sv
// I2C register-init sequencer: writes {reg,data} table entries to one 7-bit device, retrying NACKs.
// Latency: 120 quarter-bits of DIV cycles per entry, plus SCL clock-stretch cycles and retries.
// Backpressure: slave clock stretching freezes the quarter counter; start_i while busy is dropped.
`timescale 1ns/1ps
module dvi_i2c_init_seq #(
  parameter int                   CLK_HZ     = 100_000_000,
  parameter int                   I2C_HZ     = 100_000,
  parameter logic [6:0]           DEV_ADDR   = 7'h76,
  parameter int                   N_REGS     = 8,
  parameter logic [N_REGS*16-1:0] INIT_TABLE = 128'h0700_0601_0502_0403_0304_0205_0106_0007,
  parameter int                   MAX_RETRY  = 3,
  parameter bit                   AUTO_START = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] idx_o
);

  localparam int DIV = CLK_HZ / (4 * I2C_HZ);
  localparam int QW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(DIV - 1);

  if (DIV < 1) begin : g_div_chk
    $error("dvi_i2c_init_seq: CLK_HZ/(4*I2C_HZ) must be at least 1");
  end
  if (N_REGS < 1 || N_REGS > 256) begin : g_nregs_chk
    $error("dvi_i2c_init_seq: N_REGS must be in 1..256");
  end

  typedef enum logic [2:0] {IDLE, START, BITS, STOP, GAP} state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [1:0]      quarter_q, quarter_d;
  logic [4:0]      bit_q, bit_d;
  logic            nack_q, nack_d;
  logic [7:0]      retry_q, retry_d;
  logic [7:0]      idx_q, idx_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            auto_q, auto_d;

  // Table flattened to a 256-deep array so the 8-bit index selects directly.
  logic [15:0] tbl [256];
  for (genvar k = 0; k < 256; k++) begin : g_tbl
    if (k < N_REGS) begin : g_used
      assign tbl[k] = INIT_TABLE[16*k +: 16];
    end else begin : g_zero
      assign tbl[k] = 16'h0000;
    end
  end

  logic [15:0] ent;
  logic [26:0] frame;
  logic        ack_slot;
  assign ent      = tbl[idx_q];
  // Ones in the ACK slots leave SDA released for the slave.
  assign frame    = {DEV_ADDR, 1'b0, 1'b1, ent[15:8], 1'b1, ent[7:0], 1'b1};
  assign ack_slot = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

  logic scl_oe_c, sda_oe_c;
  // Decode pad drive from phase and quarter.
  always_comb begin
    scl_oe_c = 1'b0;
    sda_oe_c = 1'b0;
    case (state_q)
      START: sda_oe_c = quarter_q[1];
      BITS: begin
        scl_oe_c = ~quarter_q[1];
        sda_oe_c = ~frame[5'd26 - bit_q];
      end
      STOP: begin
        scl_oe_c = (quarter_q == 2'd0);
        sda_oe_c = (quarter_q != 2'd3);
      end
      default: ;
    endcase
  end

  logic stall, tick, phase_end;
  // A quarter with SCL released does not advance while the slave holds SCL low.
  assign stall     = (state_q != IDLE) && !scl_oe_c && !scl_i;
  assign tick      = (state_q != IDLE) && !stall && (qcnt_q == QMAX);
  assign phase_end = tick && (quarter_q == 2'd3);

  // Next-state: quarter timing, bit walk, retry and entry sequencing.
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    nack_d    = nack_q;
    retry_d   = retry_q;
    idx_d     = idx_q;
    done_d    = done_q;
    err_d     = err_q;
    auto_d    = auto_q;

    if (state_q != IDLE && !stall) begin
      qcnt_d = (qcnt_q == QMAX) ? '0 : qcnt_q + QW'(1);
    end
    if (tick) begin
      quarter_d = quarter_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (start_i || auto_q) begin
          state_d   = START;
          qcnt_d    = '0;
          quarter_d = 2'd0;
          idx_d     = 8'd0;
          retry_d   = 8'd0;
          done_d    = 1'b0;
          err_d     = 1'b0;
          auto_d    = 1'b0;
        end
      end
      START: begin
        if (phase_end) begin
          state_d = BITS;
          bit_d   = 5'd0;
          nack_d  = 1'b0;
        end
      end
      BITS: begin
        // Sample point is the last cycle of q2.
        if (tick && quarter_q == 2'd2 && ack_slot && sda_i) begin
          nack_d = 1'b1;
        end
        if (phase_end) begin
          if (nack_q || bit_q == 5'd26) state_d = STOP;
          else                          bit_d   = bit_q + 5'd1;
        end
      end
      STOP: begin
        if (phase_end) state_d = GAP;
      end
      GAP: begin
        if (phase_end) begin
          if (nack_q) begin
            if (retry_q < 8'(MAX_RETRY)) begin
              retry_d = retry_q + 8'd1;
              state_d = START;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else if (idx_q == 8'(N_REGS - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            retry_d = 8'd0;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset releases the bus immediately with no STOP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      qcnt_q    <= '0;
      quarter_q <= 2'd0;
      bit_q     <= 5'd0;
      nack_q    <= 1'b0;
      retry_q   <= 8'd0;
      idx_q     <= 8'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      auto_q    <= AUTO_START;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      nack_q    <= nack_d;
      retry_q   <= retry_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      err_q     <= err_d;
      auto_q    <= auto_d;
    end
  end

  assign scl_oe_o = scl_oe_c;
  assign sda_oe_o = sda_oe_c;
  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign idx_o    = idx_q;

endmodule

// File: tb/tb_dvi_i2c_init_seq.sv
// Bench for dvi_i2c_init_seq: bus-level slave model decodes bytes against an expected-byte queue.
// Latency measured from busy_o rising to done_o/err_o rising.
// Slave can ACK, NACK, and stretch SCL.
`timescale 1ns/1ps
module tb_dvi_i2c_init_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       scl_i, sda_i;
  logic       scl_oe_o, sda_oe_o, busy_o, done_o, err_o;
  logic [7:0] idx_o;

  int tests = 0;
  int fails = 0;

  // Slave model state
  logic [7:0] exp_q [$];
  int         len_q [$];
  int         mode = 0;        // 0 ack all, 1 nack entry-0 address once, 2 nack data of reg 49 always
  bit         nacked_once = 0;
  logic       ack_drv = 1'b0;
  int         stretch_left = 0;
  bit         stretch_arm = 0;
  bit         meas_on = 0;
  int         rel_len = 0;
  int         bitn = 0, byten = 0, bits_in = 0, trans_n = 0, attempts49 = 0;
  logic [7:0] shreg = 8'h00, cur_reg = 8'h00;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_oe = 1'b0;

  assign scl_i = !scl_oe_o && (stretch_left == 0);
  assign sda_i = !sda_oe_o && !ack_drv;

  always #5 clk = ~clk;

  dvi_i2c_init_seq #(
    .CLK_HZ(8_000_000), .I2C_HZ(1_000_000), .DEV_ADDR(7'h76), .N_REGS(2),
    .INIT_TABLE(32'h49C0_0835), .MAX_RETRY(2), .AUTO_START(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .scl_i(scl_i), .sda_i(sda_i),
    .scl_oe_o(scl_oe_o), .sda_oe_o(sda_oe_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .idx_o(idx_o)
  );

  // Slave: detect START/STOP, shift bits on SCL rise, drive ACK after each byte.
  always @(negedge clk) begin
    logic s_scl, s_sda, nk;
    logic [7:0] b;
    if (rst) begin
      bitn = 0; byten = 0; bits_in = 0; ack_drv = 1'b0; stretch_left = 0;
      meas_on = 0; prev_scl = 1'b1; prev_sda = 1'b1; prev_oe = 1'b0;
    end else begin
      if (stretch_left > 0) stretch_left--;
      else if (stretch_arm && trans_n == 0 && byten == 0 && bitn == 3 && prev_oe && !scl_oe_o) begin
        stretch_left = 10; stretch_arm = 0; meas_on = 1; rel_len = 0;
      end
      if (meas_on) begin
        if (!scl_oe_o) rel_len++;
        else meas_on = 0;
      end
      prev_oe = scl_oe_o;
      s_scl = !scl_oe_o && (stretch_left == 0);
      s_sda = !sda_oe_o && !ack_drv;
      if (s_scl && prev_scl && prev_sda && !s_sda) begin
        bitn = 0; byten = 0; bits_in = 0; shreg = 8'h00;
      end else if (s_scl && prev_scl && !prev_sda && s_sda) begin
        tests++;
        if (len_q.size() == 0) begin
          fails++; $display("FAIL stop_len: unexpected STOP after %0d bits", bits_in - 1);
        end else begin
          int el;
          el = len_q.pop_front();
          if ((bits_in - 1) !== el) begin
            fails++; $display("FAIL stop_len: got %0d bits, expected %0d", bits_in - 1, el);
          end
        end
        trans_n++;
      end else if (s_scl && !prev_scl) begin
        bits_in++;
        if (bitn < 8) begin
          shreg = {shreg[6:0], s_sda};
          bitn++;
          if (bitn == 8) begin
            b = shreg;
            if (byten == 1) cur_reg = b;
            tests++;
            if (exp_q.size() == 0) begin
              fails++; $display("FAIL byte: got %h, expected none", b);
            end else begin
              logic [7:0] e;
              e = exp_q.pop_front();
              if (b !== e) begin
                fails++; $display("FAIL byte: got %h, expected %h", b, e);
              end
            end
          end
        end else begin
          bitn = 0; byten++;
        end
      end else if (!s_scl && prev_scl) begin
        if (bitn == 8) begin
          nk = 1'b0;
          if (mode == 1 && trans_n == 0 && byten == 0 && !nacked_once) begin
            nk = 1'b1; nacked_once = 1;
          end
          if (mode == 2 && byten == 2 && cur_reg == 8'h49) begin
            nk = 1'b1; attempts49++;
          end
          ack_drv = !nk;
        end else begin
          ack_drv = 1'b0;
        end
      end
      prev_scl = s_scl;
      prev_sda = s_sda;
    end
  end

  task automatic push_entry(input logic [7:0] r, input logic [7:0] d);
    exp_q.push_back(8'hEC); exp_q.push_back(r); exp_q.push_back(d);
    len_q.push_back(27);
  endtask

  task automatic push_run();
    push_entry(8'h08, 8'h35);
    push_entry(8'h49, 8'hC0);
  endtask

  task automatic wait_end(output int lat, output bit to);
    lat = 0; to = 0;
    while (!(done_o || err_o)) begin
      @(negedge clk);
      lat++;
      if (lat > 5000) begin to = 1; break; end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (scl_oe_o !== 1'b0) begin fails++; $display("FAIL rst_scl_oe: got %b, expected 0", scl_oe_o); end
    tests++; if (sda_oe_o !== 1'b0) begin fails++; $display("FAIL rst_sda_oe: got %b, expected 0", sda_oe_o); end
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, expected 0", busy_o); end
    tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL rst_done: got %b, expected 0", done_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL rst_err: got %b, expected 0", err_o); end
    tests++; if (idx_o !== 8'd0) begin fails++; $display("FAIL rst_idx: got %0d, expected 0", idx_o); end
  endtask

  task automatic test_auto_run();
    int lat; bit to;
    mode = 0; trans_n = 0;
    push_run();
    rst = 1'b0;
    @(negedge clk);
    tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL auto_busy: got %b, expected 1", busy_o); end
    wait_end(lat, to);
    tests++; if (to) begin fails++; $display("FAIL auto_timeout: no done after %0d cycles", lat); end
    tests++; if (lat !== 480) begin fails++; $display("FAIL auto_latency: got %0d, expected 480", lat); end
    tests++; if (done_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL auto_status: done %b err %b busy %b, expected 1 0 0", done_o, err_o, busy_o); end
    tests++; if (idx_o !== 8'd1) begin fails++; $display("FAIL auto_idx: got %0d, expected 1", idx_o); end
    tests++; if (exp_q.size() != 0 || len_q.size() != 0) begin
      fails++; $display("FAIL auto_leftover: %0d bytes %0d stops outstanding, expected 0", exp_q.size(), len_q.size()); end
  endtask

  task automatic test_restart_ignore_busy();
    int lat; bit to;
    mode = 0; trans_n = 0;
    push_run();
    pulse_start();
    tests++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      fails++; $display("FAIL restart_clear: done %b busy %b, expected 0 1", done_o, busy_o); end
    repeat (100) @(negedge clk);
    pulse_start();
    wait_end(lat, to);
    lat += 101;
    tests++; if (to) begin fails++; $display("FAIL restart_timeout: no done"); end
    tests++; if (lat !== 480) begin fails++; $display("FAIL restart_latency: got %0d, expected 480", lat); end
    tests++; if (done_o !== 1'b1 || err_o !== 1'b0) begin
      fails++; $display("FAIL restart_status: done %b err %b, expected 1 0", done_o, err_o); end
    repeat (3) @(negedge clk);
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL restart_requeued: busy %b, expected 0", busy_o); end
    tests++; if (exp_q.size() != 0 || len_q.size() != 0) begin
      fails++; $display("FAIL restart_leftover: %0d bytes %0d stops outstanding, expected 0", exp_q.size(), len_q.size()); end
  endtask

  task automatic test_nack_retry();
    int lat; bit to;
    mode = 1; nacked_once = 0; trans_n = 0;
    exp_q.push_back(8'hEC); len_q.push_back(9);
    push_run();
    pulse_start();
    wait_end(lat, to);
    tests++; if (to) begin fails++; $display("FAIL nack_timeout: no done"); end
    tests++; if (lat !== 576) begin fails++; $display("FAIL nack_latency: got %0d, expected 576", lat); end
    tests++; if (done_o !== 1'b1 || err_o !== 1'b0) begin
      fails++; $display("FAIL nack_status: done %b err %b, expected 1 0", done_o, err_o); end
    tests++; if (exp_q.size() != 0 || len_q.size() != 0) begin
      fails++; $display("FAIL nack_leftover: %0d bytes %0d stops outstanding, expected 0", exp_q.size(), len_q.size()); end
    mode = 0;
  endtask

  task automatic test_retry_exhaust();
    int lat; bit to;
    mode = 2; attempts49 = 0; trans_n = 0;
    push_entry(8'h08, 8'h35);
    for (int i = 0; i < 3; i++) push_entry(8'h49, 8'hC0);
    pulse_start();
    wait_end(lat, to);
    tests++; if (to) begin fails++; $display("FAIL exhaust_timeout: no err"); end
    tests++; if (lat !== 960) begin fails++; $display("FAIL exhaust_latency: got %0d, expected 960", lat); end
    tests++; if (err_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL exhaust_status: err %b done %b busy %b, expected 1 0 0", err_o, done_o, busy_o); end
    tests++; if (idx_o !== 8'd1) begin fails++; $display("FAIL exhaust_idx: got %0d, expected 1", idx_o); end
    tests++; if (scl_oe_o !== 1'b0 || sda_oe_o !== 1'b0) begin
      fails++; $display("FAIL exhaust_bus: scl_oe %b sda_oe %b, expected 0 0", scl_oe_o, sda_oe_o); end
    tests++; if (attempts49 !== 3) begin fails++; $display("FAIL exhaust_attempts: got %0d, expected 3", attempts49); end
    tests++; if (exp_q.size() != 0 || len_q.size() != 0) begin
      fails++; $display("FAIL exhaust_leftover: %0d bytes %0d stops outstanding, expected 0", exp_q.size(), len_q.size()); end
    mode = 0;
  endtask

  task automatic test_stretch();
    int lat; bit to;
    mode = 0; trans_n = 0; rel_len = 0; stretch_arm = 1;
    push_run();
    pulse_start();
    wait_end(lat, to);
    tests++; if (to) begin fails++; $display("FAIL stretch_timeout: no done"); end
    tests++; if (lat !== 490) begin fails++; $display("FAIL stretch_latency: got %0d, expected 490", lat); end
    // Released span of bit 3 = stretched q2 (12) + q3 (2).
    tests++; if (rel_len !== 14) begin fails++; $display("FAIL stretch_release: got %0d cycles, expected 14", rel_len); end
    tests++; if (done_o !== 1'b1 || err_o !== 1'b0) begin
      fails++; $display("FAIL stretch_status: done %b err %b, expected 1 0", done_o, err_o); end
    tests++; if (exp_q.size() != 0 || len_q.size() != 0) begin
      fails++; $display("FAIL stretch_leftover: %0d bytes %0d stops outstanding, expected 0", exp_q.size(), len_q.size()); end
  endtask

  task automatic test_reset_mid();
    int lat, n; bit to;
    mode = 0; trans_n = 0;
    push_run();
    pulse_start();
    n = 0;
    while (!(byten == 2 && bitn == 3) && n < 2000) begin @(negedge clk); n++; end
    tests++; if (n >= 2000) begin fails++; $display("FAIL rmid_reach: data byte not reached"); end
    #1 rst = 1'b1;
    #1;
    tests++; if (scl_oe_o !== 1'b0 || sda_oe_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL rmid_async: scl_oe %b sda_oe %b busy %b, expected 0 0 0", scl_oe_o, sda_oe_o, busy_o); end
    exp_q.delete(); len_q.delete();
    @(negedge clk);
    trans_n = 0;
    push_run();
    rst = 1'b0;
    @(negedge clk);
    tests++; if (busy_o !== 1'b1 || idx_o !== 8'd0) begin
      fails++; $display("FAIL rmid_restart: busy %b idx %0d, expected 1 0", busy_o, idx_o); end
    wait_end(lat, to);
    tests++; if (to || lat !== 480) begin fails++; $display("FAIL rmid_latency: got %0d, expected 480", lat); end
    tests++; if (done_o !== 1'b1 || idx_o !== 8'd1) begin
      fails++; $display("FAIL rmid_status: done %b idx %0d, expected 1 1", done_o, idx_o); end
    tests++; if (exp_q.size() != 0 || len_q.size() != 0) begin
      fails++; $display("FAIL rmid_leftover: %0d bytes %0d stops outstanding, expected 0", exp_q.size(), len_q.size()); end
  endtask

  initial begin
    test_reset();
    test_auto_run();
    test_restart_ignore_busy();
    test_nack_retry();
    test_retry_exhaust();
    test_stretch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
